vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_timing_gen_if.sv | 31 +++
 rtl/vga_phase_counter.sv | 65 ++++++
 rtl/vga_timing_gen.sv | 113 +++++++++++
 tb/tb_vga_timing_gen.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : Default 640x480@60 timing constants and the phase encodings
//             shared by the timing generator, color_mapper and sprite blocks.
//  Revision : 1.0  initial release
// ============================================================================
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;

  localparam int COORD_W = 10;

  // Axis-neutral phase used inside the shared per-axis counter.
  typedef enum logic [1:0] {PH_ACT = 2'd0, PH_FP = 2'd1, PH_SP = 2'd2, PH_BP = 2'd3} phase_t;

  // Axis-specific views with the same encoding as phase_t.
  typedef enum logic [1:0] {H_ACT = 2'd0, H_FP = 2'd1, H_SP = 2'd2, H_BP = 2'd3} h_phase_t;
  typedef enum logic [1:0] {V_ACT = 2'd0, V_FP = 2'd1, V_SP = 2'd2, V_BP = 2'd3} v_phase_t;

  // Total period of one axis (active + front porch + sync + back porch).
  function automatic int span_total(input int act, input int fp, input int sp, input int bp);
    return act + fp + sp + bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen_if
//  Purpose  : Bundle of VGA timing outputs; master drives, slave consumes.
//  Revision : 1.0  initial release
// ============================================================================
interface vga_timing_gen_if;

  logic       VGA_CLK;
  logic       pixel_en;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic       VGA_SYNC_N;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       line_start;
  logic       frame_start;

  modport master (
    output VGA_CLK, pixel_en, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
    output DrawX, DrawY, line_start, frame_start
  );

  modport slave (
    input VGA_CLK, pixel_en, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
    input DrawX, DrawY, line_start, frame_start
  );

endinterface
`default_nettype wire

// File: rtl/vga_phase_counter.sv
`default_nettype none
// ============================================================================
//  Module   : vga_phase_counter
//  Purpose  : One timing axis: wrap-around position counter plus the
//             active/front/sync/back phase FSM. Next-state values are exported
//             so the parent can register sync/blank aligned with the count.
//  Revision : 1.0  initial release
// ============================================================================
module vga_phase_counter import vga_pkg::*; #(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FRONT  = H_FRONT_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BACK   = H_BACK_DEF,
  parameter int W      = COORD_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         adv_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] count_next_o,
  output phase_t       phase_next_o
);

  localparam int           TOTAL      = span_total(ACTIVE, FRONT, SYNC, BACK);
  localparam logic [W-1:0] c_act_last = W'(ACTIVE - 1);
  localparam logic [W-1:0] c_fp_last  = W'(ACTIVE + FRONT - 1);
  localparam logic [W-1:0] c_sp_last  = W'(ACTIVE + FRONT + SYNC - 1);
  localparam logic [W-1:0] c_last     = W'(TOTAL - 1);

  logic [W-1:0] count_q, count_d;
  phase_t       phase_q, phase_d;

  // Position and phase state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      phase_q <= PH_ACT;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  // Advance the count and step the phase when the count leaves each region.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (adv_i) begin
      count_d = (count_q == c_last) ? '0 : count_q + 1'b1;
      case (phase_q)
        PH_ACT:  if (count_q == c_act_last) phase_d = PH_FP;
        PH_FP:   if (count_q == c_fp_last)  phase_d = PH_SP;
        PH_SP:   if (count_q == c_sp_last)  phase_d = PH_BP;
        PH_BP:   if (count_q == c_last)     phase_d = PH_ACT;
        default: phase_d = PH_ACT;
      endcase
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign phase_next_o = phase_d;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : VGA raster timing from the system clock: Clk/2 pixel strobe,
//             pixel/line counters, active-low syncs, blank and start pulses.
//             All outputs change in the same Clk cycle as DrawX/DrawY.
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen import vga_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  vga_timing_gen_if.master vga
);

  // tog_q leads pixel_en_q by one cycle so the first strobe after reset
  // lands in the second cycle and the start pulses can be precomputed.
  logic tog_q;
  logic pixel_en_q, vga_clk_q;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic blank_n_q, blank_n_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  logic [COORD_W-1:0] w_h_count, w_h_next;
  logic [COORD_W-1:0] w_v_count, w_v_next;
  phase_t             w_h_phase_raw, w_v_phase_raw;
  h_phase_t           w_h_phase;
  v_phase_t           w_v_phase;
  logic               w_h_wrap;

  vga_phase_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(COORD_W)
  ) u_h_axis (
    .clk_i        (Clk),
    .rst_i        (Reset),
    .adv_i        (pixel_en_q),
    .count_o      (w_h_count),
    .count_next_o (w_h_next),
    .phase_next_o (w_h_phase_raw)
  );

  // A line ends when a strobed pixel rolls the column back to zero.
  assign w_h_wrap = pixel_en_q && (w_h_next == '0);

  vga_phase_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(COORD_W)
  ) u_v_axis (
    .clk_i        (Clk),
    .rst_i        (Reset),
    .adv_i        (w_h_wrap),
    .count_o      (w_v_count),
    .count_next_o (w_v_next),
    .phase_next_o (w_v_phase_raw)
  );

  assign w_h_phase = h_phase_t'(w_h_phase_raw);
  assign w_v_phase = v_phase_t'(w_v_phase_raw);

  // Decode the upcoming phases/positions so registered outputs match the counters.
  always_comb begin
    hs_d          = (w_h_phase != H_SP);
    vs_d          = (w_v_phase != V_SP);
    blank_n_d     = (w_h_phase == H_ACT) && (w_v_phase == V_ACT);
    line_start_d  = tog_q && (w_h_next == '0);
    frame_start_d = tog_q && (w_h_next == '0) && (w_v_next == '0);
  end

  // Output and strobe registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tog_q         <= 1'b0;
      pixel_en_q    <= 1'b0;
      vga_clk_q     <= 1'b1;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      tog_q         <= ~tog_q;
      pixel_en_q    <= tog_q;
      vga_clk_q     <= ~pixel_en_q;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.VGA_CLK     = vga_clk_q;
  assign vga.pixel_en    = pixel_en_q;
  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
  assign vga.VGA_BLANK_N = blank_n_q;
  assign vga.VGA_SYNC_N  = 1'b0;
  assign vga.DrawX       = w_h_count;
  assign vga.DrawY       = w_v_count;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench for vga_timing_gen using a reduced raster
//             (32 x 19) so full frames fit in a short run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, H_SYN = 8, HB = 4;
  localparam int VA = 12, VF = 2, V_SYN = 2, VB = 3;
  localparam int HT = HA + HF + H_SYN + HB;   // 32
  localparam int VT = VA + VF + V_SYN + VB;   // 19
  localparam int FRAME = 2 * HT * VT;         // 1216 Clk cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if vif();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(H_SYN), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(V_SYN), .V_BACK(VB)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .vga   (vif)
  );

  typedef struct {
    int   x;
    int   y;
    logic blank_n;
    logic hs;
    logic vs;
  } probe_t;

  probe_t tbl[12];

  int n_checks = 0;
  int n_errors = 0;

  int hs_fall1, hs_fall2, hs_fall1_x, hs_low;
  int vs_fall1, vs_fall1_y, vs_low;
  int fs1, fs2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cycle-indexed reference: k=1 is the first cycle after reset release.
  task automatic run_model(input int ncyc);
    int   mism, n, x, y;
    logic pe, vc, hs, vs, bl, ls, fs;
    logic p_hs, p_vs, p_fs;
    mism = 0;
    hs_fall1 = -1; hs_fall2 = -1; hs_fall1_x = -1; hs_low = -1;
    vs_fall1 = -1; vs_fall1_y = -1; vs_low = -1; fs1 = -1; fs2 = -1;
    p_hs = 1'b1; p_vs = 1'b1; p_fs = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      n  = (k - 1) / 2;
      x  = n % HT;
      y  = (n / HT) % VT;
      pe = (k % 2 == 0);
      vc = !((k % 2 == 1) && (k > 1));
      hs = !((x >= HA + HF) && (x < HA + HF + H_SYN));
      vs = !((y >= VA + VF) && (y < VA + VF + V_SYN));
      bl = (x < HA) && (y < VA);
      ls = pe && (x == 0);
      fs = ls && (y == 0);
      if ({vif.pixel_en, vif.VGA_CLK, vif.VGA_HS, vif.VGA_VS, vif.VGA_BLANK_N,
           vif.line_start, vif.frame_start, vif.VGA_SYNC_N} !== {pe, vc, hs, vs, bl, ls, fs, 1'b0}
          || vif.DrawX !== 10'(x) || vif.DrawY !== 10'(y)) begin
        if (mism < 3)
          $display("model diverges at cycle %0d: X=%0d Y=%0d pe=%b (want X=%0d Y=%0d pe=%b)",
                   k, vif.DrawX, vif.DrawY, vif.pixel_en, x, y, pe);
        mism++;
      end
      if (p_hs && !vif.VGA_HS) begin
        if (hs_fall1 < 0) begin hs_fall1 = k; hs_fall1_x = int'(vif.DrawX); end
        else if (hs_fall2 < 0) hs_fall2 = k;
      end
      if (!p_hs && vif.VGA_HS && hs_fall1 >= 0 && hs_low < 0) hs_low = k - hs_fall1;
      if (p_vs && !vif.VGA_VS && vs_fall1 < 0) begin vs_fall1 = k; vs_fall1_y = int'(vif.DrawY); end
      if (!p_vs && vif.VGA_VS && vs_fall1 >= 0 && vs_low < 0) vs_low = k - vs_fall1;
      if (!p_fs && vif.frame_start) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
      p_hs = vif.VGA_HS; p_vs = vif.VGA_VS; p_fs = vif.frame_start;
    end
    check("model_cycle_mismatches", mism, 0);
  endtask

  // Advance to the strobed cycle showing pixel (x, y), bounded by two frames.
  task automatic wait_pos(input int x, input int y, output logic found);
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME + 4 && !found; i++) begin
      @(negedge clk);
      if (vif.pixel_en && vif.DrawX == 10'(x) && vif.DrawY == 10'(y)) found = 1'b1;
    end
  endtask

  initial begin
    logic found;

    // Hand-computed probes on the 32x19 raster:
    // H: active 0..15, front 16..19, sync 20..27, back 28..31
    // V: active 0..11, front 12..13, sync 14..15, back 16..18
    tbl[0]  = '{15, 11, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{16,  0, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{ 0, 12, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{19,  5, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{20,  5, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{27,  5, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{28,  5, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{ 3, 13, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{ 3, 14, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{ 3, 15, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{ 3, 16, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{31, 18, 1'b0, 1'b1, 1'b1};

    // Reset held for three cycles.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pixel_en",    vif.pixel_en,    0);
    check("rst_vga_clk",     vif.VGA_CLK,     1);
    check("rst_drawx",       vif.DrawX,       0);
    check("rst_drawy",       vif.DrawY,       0);
    check("rst_hs",          vif.VGA_HS,      1);
    check("rst_vs",          vif.VGA_VS,      1);
    check("rst_blank_n",     vif.VGA_BLANK_N, 0);
    check("rst_line_start",  vif.line_start,  0);
    check("rst_frame_start", vif.frame_start, 0);
    check("rst_sync_n",      vif.VGA_SYNC_N,  0);
    rst = 1'b0;

    // Two full frames against the reference, with edge measurements.
    run_model(2 * FRAME + 10);
    check("first_frame_start_cycle", fs1, 2);
    check("frame_start_spacing",     fs2 - fs1, FRAME);
    check("hs_first_fall_x",         hs_fall1_x, HA + HF);
    check("hs_low_cycles",           hs_low, 2 * H_SYN);
    check("hs_period_cycles",        hs_fall2 - hs_fall1, 2 * HT);
    check("vs_first_fall_y",         vs_fall1_y, VA + VF);
    check("vs_low_cycles",           vs_low, 2 * V_SYN * HT);

    // Table-driven position probes.
    for (int i = 0; i < 12; i++) begin
      wait_pos(tbl[i].x, tbl[i].y, found);
      check($sformatf("probe_found_%0d_%0d", tbl[i].x, tbl[i].y), found, 1);
      check($sformatf("probe_bl_hs_vs_%0d_%0d", tbl[i].x, tbl[i].y),
            {vif.VGA_BLANK_N, vif.VGA_HS, vif.VGA_VS},
            {tbl[i].blank_n, tbl[i].hs, tbl[i].vs});
    end

    // Pixel after the last one of the frame is (0,0), visible, frame start.
    @(negedge clk);
    @(negedge clk);
    check("wrap_pixel_en",    vif.pixel_en,    1);
    check("wrap_drawx",       vif.DrawX,       0);
    check("wrap_drawy",       vif.DrawY,       0);
    check("wrap_blank_n",     vif.VGA_BLANK_N, 1);
    check("wrap_frame_start", vif.frame_start, 1);

    // One-cycle reset in the middle of a sync pulse.
    wait_pos(24, 9, found);
    check("midrst_found", found, 1);
    check("midrst_hs_before", vif.VGA_HS, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_drawx",    vif.DrawX,    0);
    check("midrst_drawy",    vif.DrawY,    0);
    check("midrst_hs",       vif.VGA_HS,   1);
    check("midrst_pixel_en", vif.pixel_en, 0);
    rst = 1'b0;
    run_model(200);
    check("midrst_first_frame_start", fs1, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
